// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: per-frame arbiter for ARP/ICMP/UDP TX streams onto the MAC TX stream, with a beat watchdog.
// Define TX_ARB_STATS_EN to add per-source frame counters and a truncation counter.
module eth_tx_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int PRIO_MODE  = 0,
    parameter int MAX_BEATS  = 190
) (
    input  logic                  tx_axis_aclk,
    input  logic                  tx_axis_areset,
    input  logic [DATA_WIDTH-1:0] arp_tx_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] arp_tx_axis_tkeep,
    input  logic                  arp_tx_axis_tvalid,
    input  logic                  arp_tx_axis_tlast,
    input  logic                  arp_tx_axis_tuser,
    output logic                  arp_tx_axis_tready,
    input  logic [DATA_WIDTH-1:0] icmp_tx_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] icmp_tx_axis_tkeep,
    input  logic                  icmp_tx_axis_tvalid,
    input  logic                  icmp_tx_axis_tlast,
    input  logic                  icmp_tx_axis_tuser,
    output logic                  icmp_tx_axis_tready,
    input  logic [DATA_WIDTH-1:0] udp_tx_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] udp_tx_axis_tkeep,
    input  logic                  udp_tx_axis_tvalid,
    input  logic                  udp_tx_axis_tlast,
    input  logic                  udp_tx_axis_tuser,
    output logic                  udp_tx_axis_tready,
    output logic [DATA_WIDTH-1:0] mac_tx_axis_tdata,
    output logic [KEEP_WIDTH-1:0] mac_tx_axis_tkeep,
    output logic                  mac_tx_axis_tvalid,
    output logic                  mac_tx_axis_tlast,
    output logic                  mac_tx_axis_tuser,
    input  logic                  mac_tx_axis_tready,
    output logic [2:0]            arb_grant,
    output logic                  arb_busy
`ifdef TX_ARB_STATS_EN
    ,
    output logic [31:0]           arp_frame_cnt,
    output logic [31:0]           icmp_frame_cnt,
    output logic [31:0]           udp_frame_cnt,
    output logic [15:0]           trunc_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;
    state_t     r_state, w_state_nxt;
    logic [2:0] r_grant, w_grant_nxt, w_req, w_last_v, w_user_v, w_ready;
    logic [2:0] w_rot, w_pick, w_rr, w_win;
    logic [1:0] r_ptr, w_ptr_nxt, w_gidx;
    logic [7:0] r_beat_cnt, w_beat_nxt;
    logic       w_src_valid, w_src_last, w_src_user, w_hs, w_trunc;
    assign w_req    = {udp_tx_axis_tvalid, icmp_tx_axis_tvalid, arp_tx_axis_tvalid};
    assign w_last_v = {udp_tx_axis_tlast, icmp_tx_axis_tlast, arp_tx_axis_tlast};
    assign w_user_v = {udp_tx_axis_tuser, icmp_tx_axis_tuser, arp_tx_axis_tuser};
    assign w_src_valid = |(w_req & r_grant);
    assign w_src_last  = |(w_last_v & r_grant);
    assign w_src_user  = |(w_user_v & r_grant);
    assign w_gidx = r_grant[2] ? 2'd2 : r_grant[1] ? 2'd1 : 2'd0;
    // Rotate requests so the source after the last grant sits at bit 0, pick lowest, rotate back.
    assign w_rot  = (r_ptr == 2'd0) ? {w_req[0], w_req[2:1]} : (r_ptr == 2'd1) ? {w_req[1:0], w_req[2]} : w_req;
    assign w_pick = w_rot & (~w_rot + 3'd1);
    assign w_rr   = (r_ptr == 2'd0) ? {w_pick[1:0], w_pick[2]} : (r_ptr == 2'd1) ? {w_pick[0], w_pick[2:1]} : w_pick;
    assign w_win  = (PRIO_MODE == 1) ? (w_req & (~w_req + 3'd1)) : w_rr;
    assign mac_tx_axis_tdata  = r_grant[0] ? arp_tx_axis_tdata : r_grant[1] ? icmp_tx_axis_tdata : udp_tx_axis_tdata;
    assign mac_tx_axis_tkeep  = r_grant[0] ? arp_tx_axis_tkeep : r_grant[1] ? icmp_tx_axis_tkeep : udp_tx_axis_tkeep;
    assign w_trunc            = (r_beat_cnt == 8'(MAX_BEATS - 1)) && !w_src_last;
    assign mac_tx_axis_tvalid = (r_state == SEND) && w_src_valid;
    assign mac_tx_axis_tlast  = w_src_last | w_trunc;
    assign mac_tx_axis_tuser  = w_src_user | w_trunc;
    assign w_hs = mac_tx_axis_tvalid && mac_tx_axis_tready;
    assign w_ready = (r_state == SEND) ? (r_grant & {3{mac_tx_axis_tready}}) : (r_state == FLUSH) ? r_grant : 3'b000;
    assign {udp_tx_axis_tready, icmp_tx_axis_tready, arp_tx_axis_tready} = w_ready;
    assign arb_grant = r_grant;
    assign arb_busy  = r_state != IDLE;
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_beat_nxt  = r_beat_cnt;
        case (r_state)
            IDLE: if (|w_req) begin
                w_grant_nxt = w_win;
                w_state_nxt = SEND;
            end
            SEND: if (w_hs) begin
                if (w_src_last) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = 3'b000;
                    w_ptr_nxt   = w_gidx;
                    w_beat_nxt  = 8'd0;
                end else begin
                    w_beat_nxt  = r_beat_cnt + 8'd1;
                    w_state_nxt = w_trunc ? FLUSH : SEND;
                end
            end
            FLUSH: if (w_src_valid && w_src_last) begin
                w_state_nxt = IDLE;
                w_grant_nxt = 3'b000;
                w_ptr_nxt   = w_gidx;
                w_beat_nxt  = 8'd0;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge tx_axis_aclk) begin
        if (tx_axis_areset) begin
            r_state    <= IDLE;
            r_grant    <= 3'b000;
            r_ptr      <= 2'd2;
            r_beat_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_ptr      <= w_ptr_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end
`ifdef TX_ARB_STATS_EN
    always_ff @(posedge tx_axis_aclk) begin
        if (tx_axis_areset) begin
            arp_frame_cnt  <= 32'd0;
            icmp_frame_cnt <= 32'd0;
            udp_frame_cnt  <= 32'd0;
            trunc_cnt      <= 16'd0;
        end else begin
            if (w_hs && mac_tx_axis_tlast && r_grant[0]) arp_frame_cnt <= arp_frame_cnt + 32'd1;
            if (w_hs && mac_tx_axis_tlast && r_grant[1]) icmp_frame_cnt <= icmp_frame_cnt + 32'd1;
            if (w_hs && mac_tx_axis_tlast && r_grant[2]) udp_frame_cnt <= udp_frame_cnt + 32'd1;
            if (w_hs && w_trunc) trunc_cnt <= trunc_cnt + 16'd1;
        end
    end
`endif
endmodule
